// File: rtl/mem_target.sv
// Memory-side responder on the shared 8-bit mem_io bus: latches an address
// byte, then serves write/read bursts from internal RAM with auto-increment.
module mem_target #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          dbg_clk,
  input  logic          rst_n,
  input  logic          mem_req,
  input  logic          rw_mem,
  inout  wire  [7:0]    mem_io,
  output logic          mem_ack,
  output logic          err,
  output logic [1:0]    o_dbg_state,
  output logic [AW-1:0] o_dbg_addr,
  output logic          o_dbg_oe
);

  // Handshake: a bus cycle is accepted on any rising edge where mem_req=1;
  // rw_mem=1 means the processor owns mem_io, rw_mem=0 means the target may
  // drive it. mem_ack rises the cycle after an accepted data byte.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_rd;
  logic          r_ack;
  logic          r_err;
  logic [7:0]    r_mem [DEPTH];

  logic w_latch;
  logic w_bad;
  logic w_wr;
  logic w_rd;
  logic w_oe;

  always_ff @(posedge dbg_clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (mem_req && rw_mem) w_next = S_DATA;
      S_DATA, S_READ: begin
        if (!mem_req)    w_next = S_IDLE;
        else if (rw_mem) w_next = S_DATA;
        else             w_next = S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch = 1'b0;
    w_bad   = 1'b0;
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    if (r_state == S_IDLE) begin
      w_latch = mem_req & rw_mem;
      w_bad   = mem_req & ~rw_mem;
    end else begin
      w_wr = mem_req & rw_mem;
      w_rd = mem_req & ~rw_mem;
    end
    // rst_n gates the driver directly so the bus frees the instant reset falls.
    w_oe = rst_n & (r_state == S_READ) & ~rw_mem;
  end

  always_ff @(posedge dbg_clk) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_rd   <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_latch)           r_addr <= mem_io[AW-1:0];
      else if (w_wr || w_rd) r_addr <= r_addr + 1'b1;
      if (w_rd) r_rd <= r_mem[r_addr];
      r_ack <= w_wr | w_rd;
      r_err <= r_err | w_bad;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge dbg_clk) begin
    if (rst_n && w_wr) r_mem[r_addr] <= mem_io;
  end

  assign mem_io      = w_oe ? r_rd : 8'bz;
  assign mem_ack     = r_ack;
  assign err         = r_err;
  assign o_dbg_state = r_state;
  assign o_dbg_addr  = r_addr;
  assign o_dbg_oe    = w_oe;

endmodule

// File: tb/tb_mem_target.sv
// Directed bench for mem_target: stimulus pushes expected acks into a queue,
// a negedge monitor pops and checks each ack against the bus.
module tb_mem_target;

  localparam int W = 10;
  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_FLIP = 2'd2;

  logic       dbg_clk;
  logic       rst_n;
  logic       mem_req;
  logic       rw_mem;
  logic [7:0] tb_drv;
  wire  [7:0] mem_io;
  logic       mem_ack;
  logic       err;
  logic [1:0] dbg_state;
  logic [7:0] dbg_addr;
  logic       dbg_oe;

  logic [W-1:0] exp_q[$];
  int tests_run;
  int failed;

  assign mem_io = rw_mem ? tb_drv : 8'bz;

  mem_target #(.DEPTH(256), .AW(8)) dut (
    .dbg_clk     (dbg_clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .rw_mem      (rw_mem),
    .mem_io      (mem_io),
    .mem_ack     (mem_ack),
    .err         (err),
    .o_dbg_state (dbg_state),
    .o_dbg_addr  (dbg_addr),
    .o_dbg_oe    (dbg_oe)
  );

  // clock / reset
  initial dbg_clk = 1'b0;
  always #5 dbg_clk = ~dbg_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic bus(input logic req, input logic rw, input logic [7:0] d);
    mem_req = req;
    rw_mem  = rw;
    tb_drv  = d;
    @(posedge dbg_clk);
    #1;
  endtask

  task automatic addr_cyc(input logic [7:0] a);
    bus(1'b1, 1'b1, a);
  endtask

  task automatic wr(input logic [7:0] d);
    exp_q.push_back({K_WR, 8'h00});
    bus(1'b1, 1'b1, d);
  endtask

  task automatic rd(input logic [7:0] d, input logic [1:0] kind);
    exp_q.push_back({kind, d});
    bus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic idle_cyc();
    bus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic mid();
    @(negedge dbg_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_req = 1'b0;
    rw_mem  = 1'b0;
    tb_drv  = 8'h00;
    repeat (2) @(posedge dbg_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    mid();
    chk({tag, "_oe"},    dbg_oe,    0);
    chk({tag, "_ack"},   mem_ack,   0);
    chk({tag, "_err"},   err,       0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_addr"},  dbg_addr,  0);
  endtask

  // scoreboard monitor
  always @(negedge dbg_clk) begin
    if (rst_n) begin
      if (rw_mem) chk("no_drive_while_rw1", dbg_oe, 0);
      if (mem_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", mem_ack, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          case (e[9:8])
            K_RD: begin
              chk("rd_oe", dbg_oe, 1);
              chk("rd_data", mem_io, e[7:0]);
            end
            K_FLIP:  chk("flip_oe", dbg_oe, 0);
            default: chk("wr_ack_oe", dbg_oe, 0);
          endcase
        end
      end
    end
  end

  initial begin
    tests_run = 0;
    failed    = 0;

    do_reset();
    check_reset_state("reset");

    // single write / readback
    addr_cyc(8'h10);
    mid();
    chk("addr_latched", dbg_addr, 8'h10);
    chk("addr_no_ack", mem_ack, 0);
    chk("state_data", dbg_state, 1);
    wr(8'hA5);
    idle_cyc();
    addr_cyc(8'h10);
    rd(8'hA5, K_RD);
    idle_cyc();

    // burst write across the wrap point, then burst read back
    addr_cyc(8'hFE);
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    idle_cyc();
    mid();
    chk("wrap_addr", dbg_addr, 8'h01);
    addr_cyc(8'hFE);
    rd(8'h01, K_RD);
    rd(8'h02, K_RD);
    rd(8'h03, K_RD);
    idle_cyc();

    // direction flip mid-burst
    addr_cyc(8'h20);
    rd(8'h00, K_FLIP);
    wr(8'h5A);
    idle_cyc();
    addr_cyc(8'h21);
    rd(8'h5A, K_RD);
    idle_cyc();

    // protocol error, then a normal transaction still works
    bus(1'b1, 1'b0, 8'h00);
    mid();
    chk("err_set", err, 1);
    chk("err_oe", dbg_oe, 0);
    chk("err_state", dbg_state, 0);
    idle_cyc();
    addr_cyc(8'h30);
    wr(8'hC3);
    idle_cyc();
    addr_cyc(8'h30);
    rd(8'hC3, K_RD);
    idle_cyc();
    mid();
    chk("err_sticky", err, 1);

    // reset while read data is on the bus
    addr_cyc(8'hFE);
    rd(8'h01, K_RD);
    bus(1'b1, 1'b0, 8'h00);
    chk("pre_reset_oe", dbg_oe, 1);
    mem_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("reset_async_release", dbg_oe, 0);
    repeat (2) @(posedge dbg_clk);
    #1;
    rst_n = 1'b1;
    check_reset_state("midreset");

    // RAM survives reset
    addr_cyc(8'h10);
    rd(8'hA5, K_RD);
    idle_cyc();
    addr_cyc(8'hFE);
    rd(8'h01, K_RD);
    rd(8'h02, K_RD);
    rd(8'h03, K_RD);
    idle_cyc();
    addr_cyc(8'h21);
    rd(8'h5A, K_RD);
    idle_cyc();
    addr_cyc(8'h30);
    rd(8'hC3, K_RD);
    idle_cyc();

    repeat (3) idle_cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mem_target.md
Name: mem_target

Overview:
- Memory-side responder for the processor's shared 8-bit bidirectional memory bus (mem_io / rw_mem).
- Latches an address byte, then serves single or burst byte writes and reads from an internal RAM with auto-incrementing address.
- Drives mem_io only when the processor has released the bus.
- Sits on the board-level bus opposite the processor core and replaces the external ROM/RAM for simulation and FPGA builds.

Parameters:
- DEPTH, 256, number of bytes in internal RAM (power of two, at most 256).
- AW, 8, address width; equals log2(DEPTH). Higher address bits of the latched byte are ignored.

Ports:
- dbg_clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mem_req  input  1  processor strobe; high = bus cycle valid this clock.
- rw_mem  input  1  bus direction. 1 = processor drives mem_io (address/write data). 0 = processor reads (target may drive).
- mem_io  inout  8  shared data/address bus.
- mem_ack  output  1  registered; high for one cycle after each accepted data byte (write) and while valid read data is driven.
- err  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, addr_q=0, rd_q=0, mem_ack=0, err=0.
  - RAM contents are not cleared.
  - mem_io output enable is additionally gated combinationally by rst_n, so the bus goes hi-Z in the same cycle rst_n falls, including mid-burst.
- Output enable: oe = rst_n & (state==READ) & ~rw_mem. mem_io = oe ? rd_q : 8'bz. Never drive while rw_mem=1, so there is no contention on a direction flip.
- FSM states: IDLE, DATA, READ.
- IDLE:
  - mem_req=1, rw_mem=1: addr_q <= mem_io[AW-1:0]; go to DATA. mem_ack stays 0 (address bytes are not acked).
  - mem_req=1, rw_mem=0: read without address. Set err=1; stay IDLE.
  - mem_req=0: hold.
- DATA:
  - mem_req=0: go to IDLE (transaction end); addr_q retained.
  - mem_req=1, rw_mem=1: RAM[addr_q] <= mem_io; addr_q <= addr_q+1; mem_ack=1 next cycle; stay DATA.
  - mem_req=1, rw_mem=0: rd_q <= RAM[addr_q]; addr_q <= addr_q+1; go to READ.
- READ:
  - Drive rd_q per the oe rule; mem_ack=1 while in READ and rw_mem=0.
  - mem_req=1, rw_mem=0: burst read. rd_q <= RAM[addr_q]; addr_q++; stay READ. Sustains one byte per clock.
  - mem_req=1, rw_mem=1: write as in DATA; go to DATA.
  - mem_req=0: go to IDLE; release bus.
- Read latency: the byte requested at edge N is on mem_io during cycle N+1.
- Address wrap: addr_q increments modulo DEPTH (DEPTH-1 -> 0). No error on wrap.
- Read-after-write to the same address in consecutive cycles returns the newly written byte: RAM write happens at edge N; the read at edge N+1 sees it.
- mem_ack is registered and is 0 in IDLE and on any cycle with mem_req=0 at the previous edge.
- err only sets, never clears except on reset. Setting err does not block further transactions.

Test Plan:
- Reset then idle: rst_n=0 for 2 clocks, release -> mem_io=Z, mem_ack=0, err=0, state IDLE.
- Single write/read:
  - Write: addr 0x10, then write 0xA5 with mem_req held -> mem_ack=1 one cycle after the data edge.
  - Read back: new transaction, addr 0x10, then rw_mem=0 -> mem_io=0xA5 in the following cycle, mem_ack=1.
- Burst with wrap:
  - Write: addr 0xFE, write bytes 0x01,0x02,0x03 -> RAM[0xFE]=0x01, RAM[0xFF]=0x02, RAM[0x00]=0x03.
  - Read back: burst read from 0xFE returns 0x01,0x02,0x03 on consecutive cycles.
- Direction flip mid-burst: addr 0x20, read one byte, then rw_mem=1 with 0x5A -> mem_io never driven by the target while rw_mem=1 (no X on bus); RAM[0x21]=0x5A.
- Protocol error: from IDLE assert mem_req=1, rw_mem=0 -> err=1 next cycle, mem_io stays Z. A subsequent valid transaction still works and err stays 1.
- Reset mid-read burst: drop rst_n while mem_io is driven -> mem_io=Z in the same cycle. After release: state IDLE, addr_q=0, and RAM contents written earlier are intact on readback.
